// File: rtl/present80_iter.sv
// Round-iterative PRESENT-80 encryption engine.
// One round per cycle; valid/ready on input and output.
module present80_iter #(
  parameter int NROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] pt,
  input  logic [79:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ct
);

  if (NROUNDS < 1 || NROUNDS > 31) begin : g_bad_nrounds
    $error("present80_iter: NROUNDS must be in 1..31");
  end

  localparam logic [4:0] LAST = 5'(NROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [63:0] sp, sn, sx, pl;
  logic [79:0] kp, kn, kr;
  logic [4:0]  rc;
  logic        r0;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sx[4*i +: 4] = sbox(sp[4*i +: 4]);
  end

  for (genvar i = 0; i < 64; i++) begin : g_perm
    assign pl[(i == 63) ? 63 : ((i * 16) % 63)] = sx[i];
  end

  // Key schedule step and round output; round 0 is only the whitening xor
  always_comb begin
    kr = {kp[18:0], kp[79:19]};
    kr[79:76] = sbox(kr[79:76]);
    kr[19:15] = kr[19:15] ^ rc;
    if (r0) begin
      kn = kp;
      sn = sp ^ kp[79:16];
    end else begin
      kn = kr;
      sn = pl ^ kr[79:16];
    end
  end

  // Next-state, datapath steering and register loads
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    sp      = state_q;
    kp      = key_q;
    rc      = cnt_q;
    r0      = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        sp = pt;
        kp = key;
        r0 = 1'b1;
        if (in_valid) begin
          state_d = sn;
          key_d   = kn;
          cnt_d   = 5'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = sn;
        key_d   = kn;
        if (cnt_q == LAST) fsm_d = DONE;
        else cnt_d = cnt_q + 5'd1;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State, key and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign ct        = out_valid ? state_q : 64'd0;

endmodule

// File: tb/tb_present80_iter.sv
// Bench for present80_iter: known vectors, random
// blocks against a reference model, stall, reset, streaming.
module tb_present80_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pt;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ct;

  int n_cmp = 0;
  int n_bad = 0;

  present80_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_enc(input logic [63:0] p,
                                          input logic [79:0] k);
    logic [3:0]  sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0,
                             4'hA, 4'hD, 4'h3, 4'hE, 4'hF, 4'h8,
                             4'h4, 4'h7, 4'h1, 4'h2};
    logic [63:0] rk [32];
    logic [79:0] kr;
    logic [63:0] s, t;
    int          pos;
    kr = k;
    for (int i = 0; i < 32; i++) begin
      rk[i] = kr[79:16];
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sb[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(i + 1);
    end
    s = p;
    for (int r = 0; r < 31; r++) begin
      s = s ^ rk[r];
      t = '0;
      for (int n = 0; n < 16; n++)
        t = t | (64'(sb[4'(s >> (4 * n))]) << (4 * n));
      s = '0;
      for (int b = 0; b < 64; b++) begin
        pos = (b == 63) ? 63 : (16 * b) % 63;
        s = s | (((t >> b) & 64'd1) << pos);
      end
    end
    return s ^ rk[31];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [79:0] rnd80();
    return 80'({$urandom, $urandom, $urandom});
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Handshake p/k in, then count cycles until out_valid.
  task automatic run_block(input string tag,
                           input logic [63:0] p,
                           input logic [79:0] k,
                           input bit tog,
                           output logic [63:0] got,
                           output int lat);
    wait_ready(tag);
    pt = p;
    key = k;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    got = '0;
    while (lat < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
      if (tog) begin
        pt = rnd64();
        key = rnd80();
        in_valid = ($urandom_range(0, 1) == 1);
      end
    end
    in_valid = 1'b0;
    if (!out_valid) chk({tag, "_done_timeout"}, 0, 1);
    got = ct;
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 80'(in_ready), 1);
    chk({tag, "_idle_ct"}, 80'(ct), 0);
  endtask

  task automatic vec(input string tag,
                     input logic [63:0] p,
                     input logic [79:0] k,
                     input logic [63:0] exp,
                     input bit tog);
    logic [63:0] got;
    int lat;
    run_block(tag, p, k, tog, got, lat);
    chk({tag, "_lat"}, 80'(lat), 32);
    chk({tag, "_ct"}, 80'(got), 80'(exp));
    chk({tag, "_model"}, 80'(got), 80'(ref_enc(p, k)));
    take_out(tag);
  endtask

  initial begin
    logic [63:0] got, held, p0, sq [4];
    logic [79:0] k0, kq [4];
    int lat, c, ni, no, last_t;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    pt = '0;
    key = '0;
    #1;
    chk("rst_in_ready", 80'(in_ready), 1);
    chk("rst_out_valid", 80'(out_valid), 0);
    chk("rst_ct", 80'(ct), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 80'(in_ready), 1);
    chk("post_rst_ct", 80'(ct), 0);

    vec("v_zero", 64'd0, 80'd0, 64'h5579C1387B228445, 1'b0);
    vec("v_k1", 64'd0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0);
    vec("v_p1", {64{1'b1}}, 80'd0, 64'hA112FFC72F68417B, 1'b0);
    vec("v_all1", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0);
    vec("v_tog", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b1);

    for (int i = 0; i < 4; i++) begin
      p0 = rnd64();
      k0 = rnd80();
      run_block("rand", p0, k0, 1'b1, got, lat);
      chk("rand_lat", 80'(lat), 32);
      chk("rand_ct", 80'(got), 80'(ref_enc(p0, k0)));
      take_out("rand");
    end

    p0 = rnd64();
    k0 = rnd80();
    run_block("stall", p0, k0, 1'b0, held, lat);
    chk("stall_ct", 80'(held), 80'(ref_enc(p0, k0)));
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin
        pt = rnd64();
        key = rnd80();
        in_valid = 1'b1;
      end
      if (i == 22) in_valid = 1'b0;
      @(negedge clk);
      chk("stall_hold_ct", 80'(ct), 80'(held));
      chk("stall_in_ready", 80'(in_ready), 0);
      chk("stall_out_valid", 80'(out_valid), 1);
    end
    in_valid = 1'b0;
    take_out("stall");
    chk("stall_out_low", 80'(out_valid), 0);

    p0 = rnd64();
    k0 = rnd80();
    wait_ready("abort");
    pt = p0;
    key = k0;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 80'(out_valid), 0);
    chk("abort_ct", 80'(ct), 0);
    chk("abort_in_ready", 80'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p0 = rnd64();
    k0 = rnd80();
    run_block("after_rst", p0, k0, 1'b0, got, lat);
    chk("after_rst_lat", 80'(lat), 32);
    chk("after_rst_ct", 80'(got), 80'(ref_enc(p0, k0)));
    take_out("after_rst");

    sq[0] = 64'd0;        kq[0] = 80'd0;
    sq[1] = 64'd0;        kq[1] = {80{1'b1}};
    sq[2] = {64{1'b1}};   kq[2] = 80'd0;
    sq[3] = {64{1'b1}};   kq[3] = {80{1'b1}};
    ni = 0;
    no = 0;
    last_t = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (c = 0; c < 300 && no < 4; c++) begin
      if (in_ready) begin
        if (ni < 4) begin
          pt = sq[ni];
          key = kq[ni];
          ni++;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        chk("b2b_ct", 80'(ct), 80'(ref_enc(sq[no], kq[no])));
        if (no > 0) chk("b2b_gap", 80'(c - last_t), 33);
        last_t = c;
        no++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 80'(no), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
